// File: rtl/pep9_fetch_pkg.sv
// Shared types and opcode constants for the Pep9 fetch and decode stages.
package pep9_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    ERR   = 3'd4
  } fetch_state_t;

  localparam logic [7:0] OPC_UNARY_MAX = 8'h11;
  localparam logic [7:0] OPC_NOP0      = 8'h26;
  localparam logic [7:0] OPC_NOP1      = 8'h27;

  // Unary instructions carry no operand specifier.
  function automatic bit is_unary(input logic [7:0] opcode);
    return (opcode <= OPC_UNARY_MAX) || (opcode == OPC_NOP0) || (opcode == OPC_NOP1);
  endfunction

endpackage

// File: rtl/pep9_len_decode.sv
// Combinational Pep9 opcode -> instruction length (1 = unary, 3 = nonunary).
module pep9_len_decode
  import pep9_fetch_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] instr_len
);

  // Length lookup from the opcode class.
  always_comb begin
    instr_len = 2'd3;
    if (is_unary(opcode)) begin
      instr_len = 2'd1;
    end else begin
      instr_len = 2'd3;
    end
  end

endmodule

// File: rtl/pep9_fetch_unit.sv
// Pep9 instruction fetch stage: reads opcode and operand bytes through apb_top,
// assembles the instruction and next PC, and aborts on a bus that never completes.
module pep9_fetch_unit
  import pep9_fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int PC_W           = 16
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic [PC_W-1:0] pc_in,
  output logic            fetch_busy,
  output logic            instr_valid,
  output logic [23:0]     instr_out,
  output logic [1:0]      instr_len,
  output logic [PC_W-1:0] next_pc,
  output logic            fetch_err,
  output logic [PC_W-1:0] address,
  output logic [7:0]      writeData,
  output logic            we,
  input  logic [7:0]      readData,
  input  logic            done
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  fetch_state_t    state_r, state_s;
  logic [PC_W-1:0] base_pc_r, base_pc_s;
  logic [1:0]      idx_r, idx_s;
  logic [WD_W-1:0] wdog_r, wdog_s;
  logic [7:0]      opc_r, opc_s;
  logic [7:0]      hi_r, hi_s;
  logic [PC_W-1:0] address_r, address_s;
  logic [23:0]     instr_out_r, instr_out_s;
  logic [1:0]      instr_len_r, instr_len_s;
  logic [PC_W-1:0] next_pc_r, next_pc_s;
  logic            valid_r, valid_s;
  logic            err_r, err_s;
  logic            busy_r;
  logic [1:0]      dec_len_s;

  pep9_len_decode u_len_decode (
    .opcode    (readData),
    .instr_len (dec_len_s)
  );

  // Next-state and next-output logic for the fetch sequencer.
  always_comb begin
    state_s     = state_r;
    base_pc_s   = base_pc_r;
    idx_s       = idx_r;
    wdog_s      = wdog_r;
    opc_s       = opc_r;
    hi_s        = hi_r;
    address_s   = address_r;
    instr_out_s = instr_out_r;
    instr_len_s = instr_len_r;
    next_pc_s   = next_pc_r;
    valid_s     = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (fetch_req) begin
          base_pc_s = pc_in;
          address_s = pc_in;
          idx_s     = 2'd0;
          state_s   = ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      // apb_top needs one cycle of stable address; done seen here is stale.
      ADDR: begin
        wdog_s  = '0;
        state_s = WAIT;
      end
      WAIT: begin
        if (done) begin
          case (idx_r)
            2'd0: begin
              opc_s = readData;
              if (dec_len_s == 2'd1) begin
                instr_out_s = {readData, 16'h0000};
                instr_len_s = 2'd1;
                next_pc_s   = base_pc_r + PC_W'(1);
                valid_s     = 1'b1;
                state_s     = VALID;
              end else begin
                idx_s     = 2'd1;
                address_s = base_pc_r + PC_W'(1);
                state_s   = ADDR;
              end
            end
            2'd1: begin
              hi_s      = readData;
              idx_s     = 2'd2;
              address_s = base_pc_r + PC_W'(2);
              state_s   = ADDR;
            end
            2'd2: begin
              instr_out_s = {opc_r, hi_r, readData};
              instr_len_s = 2'd3;
              next_pc_s   = base_pc_r + PC_W'(3);
              valid_s     = 1'b1;
              state_s     = VALID;
            end
            default: begin
              state_s = IDLE;
            end
          endcase
        end else if (wdog_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
          err_s   = 1'b1;
          state_s = ERR;
        end else begin
          wdog_s = wdog_r + WD_W'(1);
        end
      end
      VALID: begin
        state_s = IDLE;
      end
      ERR: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      base_pc_r   <= '0;
      idx_r       <= 2'd0;
      wdog_r      <= '0;
      opc_r       <= 8'h00;
      hi_r        <= 8'h00;
      address_r   <= '0;
      instr_out_r <= 24'h000000;
      instr_len_r <= 2'd0;
      next_pc_r   <= '0;
      valid_r     <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      base_pc_r   <= base_pc_s;
      idx_r       <= idx_s;
      wdog_r      <= wdog_s;
      opc_r       <= opc_s;
      hi_r        <= hi_s;
      address_r   <= address_s;
      instr_out_r <= instr_out_s;
      instr_len_r <= instr_len_s;
      next_pc_r   <= next_pc_s;
      valid_r     <= valid_s;
      err_r       <= err_s;
      busy_r      <= (state_s != IDLE);
    end
  end

  assign fetch_busy  = busy_r;
  assign instr_valid = valid_r;
  assign instr_out   = instr_out_r;
  assign instr_len   = instr_len_r;
  assign next_pc     = next_pc_r;
  assign fetch_err   = err_r;
  assign address     = address_r;
  assign writeData   = 8'h00;
  assign we          = 1'b0;

endmodule

// File: tb/tb_pep9_fetch_unit.sv
// Self-checking bench for pep9_fetch_unit: a byte-array memory behind a
// configurable slave, and a reference model built from the Pep9 length rules.
module tb_pep9_fetch_unit;

  localparam int TIMEOUT = 64;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [15:0] pc_in;
  logic        fetch_busy, instr_valid, fetch_err, we, done;
  logic [23:0] instr_out;
  logic [1:0]  instr_len;
  logic [15:0] next_pc, address;
  logic [7:0]  writeData, readData;

  pep9_fetch_unit #(.TIMEOUT_CYCLES(TIMEOUT), .PC_W(16)) dut (
    .sysclk(sysclk), .reset(reset), .fetch_req(fetch_req), .pc_in(pc_in),
    .fetch_busy(fetch_busy), .instr_valid(instr_valid), .instr_out(instr_out),
    .instr_len(instr_len), .next_pc(next_pc), .fetch_err(fetch_err),
    .address(address), .writeData(writeData), .we(we),
    .readData(readData), .done(done)
  );

  always #5 sysclk = ~sysclk;

  logic [7:0]  mem [0:65535];
  int          slave_mode = 0;  // 0 silent, 1 random done, 2 stray done then real done
  logic [15:0] prev_addr;
  int          since;
  bit          bad_we = 1'b0;
  int          checks = 0, passed = 0, fails = 0;
  logic [23:0] last_instr = 24'h0;
  logic [1:0]  last_len = 2'd0;
  logic [15:0] last_npc = 16'h0;

  // Bus slave plus a watch on the write-side outputs.
  always @(negedge sysclk) begin
    case (slave_mode)
      1: begin
        if ($urandom_range(0, 2) == 0) begin
          done = 1'b1; readData = mem[address];
        end else begin
          done = 1'b0; readData = 8'($urandom);
        end
      end
      2: begin
        if (address !== prev_addr) begin
          prev_addr = address; since = 0;
          done = 1'b1; readData = ~mem[address];
        end else begin
          since++;
          done = (since == 2);
          readData = done ? mem[address] : 8'hEE;
        end
      end
      default: begin
        done = 1'b0; readData = 8'h00;
      end
    endcase
    if (we !== 1'b0 || writeData !== 8'h00) bad_we = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [15:0] pc, input bit hold, input bit expect_err,
                          output int edges);
    logic [15:0] alog[$];
    int          vcnt, ecnt;
    logic [7:0]  opc;
    bit          unary;
    logic [23:0] ei;
    logic [1:0]  el;
    vcnt = 0; ecnt = 0; edges = 0;
    @(negedge sysclk);
    fetch_req = 1'b1; pc_in = pc;
    @(posedge sysclk);
    for (int n = 0; n < 300; n++) begin
      @(negedge sysclk);
      if (!hold) fetch_req = 1'b0;
      if (fetch_busy && (alog.size() == 0 || alog[$] !== address)) alog.push_back(address);
      edges++;
      if (instr_valid) vcnt++;
      if (fetch_err) ecnt++;
      if (instr_valid || fetch_err) break;
    end
    if (expect_err) begin
      chk("err_pulse", 32'(ecnt), 32'd1);
      chk("err_no_valid", 32'(vcnt), 32'd0);
      chk("err_instr_keep", 32'(instr_out), 32'(last_instr));
      chk("err_len_keep", 32'(instr_len), 32'(last_len));
      chk("err_npc_keep", 32'(next_pc), 32'(last_npc));
      chk("err_addr_count", 32'(alog.size()), 32'd1);
    end else begin
      opc   = mem[pc];
      unary = (opc <= 8'h11) || (opc == 8'h26) || (opc == 8'h27);
      el    = unary ? 2'd1 : 2'd3;
      ei    = unary ? {opc, 16'h0000} : {opc, mem[pc + 16'd1], mem[pc + 16'd2]};
      chk("valid_pulse", 32'(vcnt), 32'd1);
      chk("no_err", 32'(ecnt), 32'd0);
      chk("instr_out", 32'(instr_out), 32'(ei));
      chk("instr_len", 32'(instr_len), 32'(el));
      chk("next_pc", 32'(next_pc), 32'(16'(pc + 16'(el))));
      chk("addr_count", 32'(alog.size()), 32'(el));
      for (int i = 0; i < alog.size() && i < 3; i++)
        chk("addr_order", 32'(alog[i]), 32'(16'(pc + 16'(i))));
      last_instr = ei; last_len = el; last_npc = 16'(pc + 16'(el));
    end
    @(negedge sysclk);
    fetch_req = 1'b0;
    chk("valid_one_cycle", 32'(instr_valid), 32'd0);
    chk("err_one_cycle", 32'(fetch_err), 32'd0);
    chk("idle_after", 32'(fetch_busy), 32'd0);
  endtask

  initial begin
    int          edges;
    int          seen;
    logic [15:0] rpc;
    logic [7:0]  opcs [6];
    fetch_req = 1'b0; pc_in = 16'h0000; done = 1'b0; readData = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    reset = 1'b1;
    #1;
    chk("rst_address", 32'(address), 32'h0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'h0);
    chk("rst_len", 32'(instr_len), 32'd0);
    chk("rst_npc", 32'(next_pc), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_we", 32'({we, writeData}), 32'h0);
    @(negedge sysclk); @(negedge sysclk);
    reset = 1'b0;
    slave_mode = 1;

    mem[16'h0400] = 8'hC0; mem[16'h0401] = 8'h00; mem[16'h0402] = 8'h2A;
    do_fetch(16'h0400, 1'b0, 1'b0, edges);
    chk("nonunary_word", 32'(instr_out), 32'hC0002A);
    mem[16'h0500] = 8'h0A;
    do_fetch(16'h0500, 1'b0, 1'b0, edges);
    chk("unary_word", 32'(instr_out), 32'h0A0000);
    mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h56;
    do_fetch(16'hFFFF, 1'b0, 1'b0, edges);
    chk("wrap_word", 32'(instr_out), 32'h123456);
    chk("wrap_npc", 32'(next_pc), 32'h0002);
    mem[16'hFFFE] = 8'h40;
    do_fetch(16'hFFFE, 1'b0, 1'b0, edges);
    chk("wrap2_npc", 32'(next_pc), 32'h0001);

    opcs = '{8'h11, 8'h27, 8'h12, 8'h28, 8'h26, 8'h00};
    for (int i = 0; i < 6; i++) begin
      mem[16'h0600 + 16'(i * 16)] = opcs[i];
      do_fetch(16'h0600 + 16'(i * 16), 1'b0, 1'b0, edges);
    end

    for (int i = 0; i < 20; i++) begin
      rpc = 16'($urandom);
      do_fetch(rpc, 1'b0, 1'b0, edges);
    end

    slave_mode = 2; prev_addr = 16'hxxxx;
    mem[16'h0800] = 8'hC0;
    do_fetch(16'h0800, 1'b0, 1'b0, edges);
    mem[16'h0810] = 8'h05;
    do_fetch(16'h0810, 1'b0, 1'b0, edges);

    slave_mode = 1;
    do_fetch(16'h0400, 1'b1, 1'b0, edges);
    mem[16'h0900] = 8'h01;
    do_fetch(16'h0900, 1'b1, 1'b0, edges);

    slave_mode = 0;
    do_fetch(16'h0100, 1'b0, 1'b1, edges);
    chk("timeout_latency", 32'(edges), 32'(TIMEOUT + 2));
    slave_mode = 1;
    do_fetch(16'h0100, 1'b0, 1'b0, edges);

    mem[16'h0700] = 8'hC1;
    @(negedge sysclk);
    fetch_req = 1'b1; pc_in = 16'h0700;
    @(negedge sysclk);
    fetch_req = 1'b0;
    seen = 0;
    for (int n = 0; n < 200 && seen == 0; n++) begin
      if (address === 16'h0701) begin
        seen = 1;
        slave_mode = 0;
      end else begin
        @(negedge sysclk);
      end
    end
    chk("reached_byte2", 32'(seen), 32'd1);
    @(negedge sysclk); @(negedge sysclk);
    reset = 1'b1;
    #1;
    chk("midrst_address", 32'(address), 32'h0);
    chk("midrst_busy", 32'(fetch_busy), 32'd0);
    chk("midrst_instr", 32'(instr_out), 32'h0);
    chk("midrst_len", 32'(instr_len), 32'd0);
    chk("midrst_npc", 32'(next_pc), 32'h0);
    @(negedge sysclk);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge sysclk);
      if (instr_valid || fetch_err || fetch_busy) seen++;
    end
    chk("midrst_quiet", 32'(seen), 32'd0);

    slave_mode = 1;
    do_fetch(16'h0700, 1'b0, 1'b0, edges);
    chk("never_write", 32'(bad_we), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
